// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: selects PC+4 / branch / jump / exception vector, handles stall, flush and boot.
// Optional MIPS-style branch delay slot is enabled by defining BRANCH_DELAY_SLOT_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned PC_INCR      = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_exception,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_add_result,
  output logic        o_instr_valid,
  output logic        o_flush_if,
  output logic        o_misaligned,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    S_BOOT     = 2'd0,
    S_RUN      = 2'd1,
    S_STALL    = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  localparam logic [31:0] INCR = 32'(PC_INCR);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] w_next_pc;
  logic        r_instr_valid;
  logic        r_flush_if;
  logic        r_misaligned;
  logic        w_next_misaligned;
  logic [31:0] w_req_target;
  logic [31:0] w_req_aligned;
  logic [31:0] w_pc_incr;

`ifdef BRANCH_DELAY_SLOT_EN
  logic        r_pend_valid;
  logic [31:0] r_pend_target;
  logic        w_next_pend_valid;
  logic [31:0] w_next_pend_target;
`endif

  assign w_pc_incr       = r_pc + INCR;
  assign w_req_target    = i_jump ? i_jump_target : i_branch_target;
  assign w_req_aligned   = {w_req_target[31:2], 2'b00};

  // Next-state, next-PC and misalignment selection
  always_comb begin
    w_next_state      = r_state;
    w_next_pc         = r_pc;
    w_next_misaligned = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
    w_next_pend_valid  = r_pend_valid;
    w_next_pend_target = r_pend_target;
`endif
    case (r_state)
      S_BOOT: begin
        w_next_state = S_RUN;
      end
      S_RUN, S_STALL: begin
        if (i_exception) begin
          w_next_pc    = EXC_VECTOR;
          w_next_state = S_REDIRECT;
`ifdef BRANCH_DELAY_SLOT_EN
          w_next_pend_valid = 1'b0;
`endif
        end
`ifdef BRANCH_DELAY_SLOT_EN
        // Delay slot already fetched: hold on stall, else go to the latched target
        else if (r_pend_valid) begin
          if (i_stall) begin
            w_next_state = S_STALL;
          end else begin
            w_next_pc         = r_pend_target;
            w_next_pend_valid = 1'b0;
            w_next_state      = S_RUN;
          end
        end else if (i_jump || i_branch_taken) begin
          w_next_pend_valid  = 1'b1;
          w_next_pend_target = w_req_aligned;
          w_next_misaligned  = |w_req_target[1:0];
          w_next_pc          = w_pc_incr;
          w_next_state       = S_RUN;
        end
`else
        else if (i_jump || i_branch_taken) begin
          w_next_pc         = w_req_aligned;
          w_next_misaligned = |w_req_target[1:0];
          w_next_state      = S_REDIRECT;
        end
`endif
        else if (i_stall) begin
          w_next_state = S_STALL;
        end else begin
          w_next_pc    = w_pc_incr;
          w_next_state = S_RUN;
        end
      end
      S_REDIRECT: begin
        // Jump/branch here come from the flushed path and are dropped
        if (i_exception) begin
          w_next_pc    = EXC_VECTOR;
          w_next_state = S_REDIRECT;
        end else begin
          w_next_pc    = w_pc_incr;
          w_next_state = S_RUN;
        end
      end
      default: begin
        w_next_pc    = RESET_VECTOR;
        w_next_state = S_BOOT;
      end
    endcase
  end

  // State, PC and registered status outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_VECTOR;
      r_instr_valid <= 1'b0;
      r_flush_if    <= 1'b0;
      r_misaligned  <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_pc          <= w_next_pc;
      r_instr_valid <= (w_next_state == S_RUN) || (w_next_state == S_STALL);
      r_flush_if    <= (w_next_state == S_REDIRECT);
      r_misaligned  <= w_next_misaligned;
    end
  end

`ifdef BRANCH_DELAY_SLOT_EN
  // Pending delay-slot target
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'h0000_0000;
    end else begin
      r_pend_valid  <= w_next_pend_valid;
      r_pend_target <= w_next_pend_target;
    end
  end
`endif

  assign o_pc            = r_pc;
  assign o_pc_add_result = w_pc_incr;
  assign o_instr_valid   = r_instr_valid;
  assign o_flush_if      = r_flush_if;
  assign o_misaligned    = r_misaligned;
  assign o_state         = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expectations follow BRANCH_DELAY_SLOT_EN when defined.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exception;
  logic [31:0] pc;
  logic [31:0] pc_add_result;
  logic        instr_valid;
  logic        flush_if;
  logic        misaligned;
  logic [1:0]  state;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [1:0] BOOT = 2'd0, RUN = 2'd1, STL = 2'd2, RDR = 2'd3;

  pc_sequencer dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_stall         (stall),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_jump          (jump),
    .i_jump_target   (jump_target),
    .i_exception     (exception),
    .o_pc            (pc),
    .o_pc_add_result (pc_add_result),
    .o_instr_valid   (instr_valid),
    .o_flush_if      (flush_if),
    .o_misaligned    (misaligned),
    .o_state         (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [1:0] e_state,
                         input logic e_valid, input logic e_flush, input logic e_mis);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".add"}, pc_add_result, e_pc + 32'd4);
    chk({tag, ".state"}, {30'd0, state}, {30'd0, e_state});
    chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, e_valid});
    chk({tag, ".flush"}, {31'd0, flush_if}, {31'd0, e_flush});
    chk({tag, ".mis"}, {31'd0, misaligned}, {31'd0, e_mis});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0; exception = 1'b0;

    // 1. reset, boot, sequential fetch
    tick(); tick();
    chk_all("reset", 32'h0, BOOT, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(); chk_all("run0", 32'h0, RUN, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("run4", 32'h4, RUN, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("run8", 32'h8, RUN, 1'b1, 1'b0, 1'b0);

    // 2. stall three cycles at PC=8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all("stall", 32'h8, STL, 1'b1, 1'b0, 1'b0);
    end
    stall = 1'b0;
    tick(); chk_all("unstall12", 32'hC, RUN, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("run16", 32'h10, RUN, 1'b1, 1'b0, 1'b0);

    // 3. branch to 40h
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    branch_taken = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
    chk_all("br_slot", 32'h14, RUN, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("br_tgt", 32'h40, RUN, 1'b1, 1'b0, 1'b0);
`else
    chk_all("br_tgt", 32'h40, RDR, 1'b0, 1'b1, 1'b0);
`endif
    tick(); chk_all("br_next", 32'h44, RUN, 1'b1, 1'b0, 1'b0);

    // 4. exception beats jump and stall; branch in REDIRECT ignored
    exception = 1'b1; jump = 1'b1; jump_target = 32'h100; stall = 1'b1;
    tick(); chk_all("exc", 32'h80, RDR, 1'b0, 1'b1, 1'b0);
    exception = 1'b0; jump = 1'b0; stall = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h200;
    tick(); chk_all("rdr_ign", 32'h84, RUN, 1'b1, 1'b0, 1'b0);
    branch_taken = 1'b0;

    // 5. misaligned jump, then wrap-around
    jump = 1'b1; jump_target = 32'h103;
    tick();
    jump = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
    chk_all("mis_slot", 32'h88, RUN, 1'b1, 1'b0, 1'b1);
    tick(); chk_all("mis_tgt", 32'h100, RUN, 1'b1, 1'b0, 1'b0);
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick(); jump = 1'b0;
    chk_all("wrap_slot", 32'h104, RUN, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("wrap_top", 32'hFFFF_FFFC, RUN, 1'b1, 1'b0, 1'b0);
    chk("wrap_add", pc_add_result, 32'h0);
    tick(); chk_all("wrap0", 32'h0, RUN, 1'b1, 1'b0, 1'b0);
`else
    chk_all("mis_tgt", 32'h100, RDR, 1'b0, 1'b1, 1'b1);
    tick(); chk_all("mis_next", 32'h104, RUN, 1'b1, 1'b0, 1'b0);
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick(); jump = 1'b0;
    chk_all("wrap_top", 32'hFFFF_FFFC, RDR, 1'b0, 1'b1, 1'b0);
    chk("wrap_add", pc_add_result, 32'h0);
    tick(); chk_all("wrap0", 32'h0, RUN, 1'b1, 1'b0, 1'b0);
`endif

    // 6. reset during redirect (or with pending target) and during stall
    branch_taken = 1'b1; branch_target = 32'h300;
    tick(); branch_taken = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
    chk_all("pend", 32'h4, RUN, 1'b1, 1'b0, 1'b0);
`else
    chk_all("rdr300", 32'h300, RDR, 1'b0, 1'b1, 1'b0);
`endif
    reset = 1'b1;
    tick(); chk_all("rst_rdr", 32'h0, BOOT, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(); chk_all("rst_run0", 32'h0, RUN, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("rst_run4", 32'h4, RUN, 1'b1, 1'b0, 1'b0);
    stall = 1'b1;
    tick(); chk_all("stall4", 32'h4, STL, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick(); chk_all("rst_stall", 32'h0, BOOT, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    // stall has no effect in BOOT
    tick(); chk_all("boot_ign", 32'h0, RUN, 1'b1, 1'b0, 1'b0);
    stall = 1'b0;
    tick(); chk_all("post4", 32'h4, RUN, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
